// File: rtl/mips_pipe_shifter.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready flow control and a sideband tag.
// One mux level per shamt bit; a register stage closes every REG_EVERY levels and after the last.
module mips_pipe_shifter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned TAG_W     = 5,
  localparam int unsigned LEVELS   = $clog2(WIDTH),
  localparam int unsigned LAT      = (LEVELS + REG_EVERY - 1) / REG_EVERY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [LEVELS-1:0] in_shamt,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_zero
);

  typedef enum logic [1:0] {OpSll = 2'b00, OpSrl = 2'b01, OpSra = 2'b10, OpRor = 2'b11} op_e;

  // SRA fill comes from the sign captured at the input, never from intermediate data.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input logic             sign,
                                                   input int unsigned      amt);
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
    unique case (op_e'(op))
      OpSll:   res = d << amt;
      OpSrl:   res = d >> amt;
      OpSra:   res = (d >> amt) | fill;
      OpRor:   res = (d >> amt) | (d << (WIDTH - amt));
      default: res = d;
    endcase
    return res;
  endfunction

  logic advance;

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    logic              src_valid;
    logic [WIDTH-1:0]  src_data;
    logic [LEVELS-1:0] src_shamt;
    logic [1:0]        src_op;
    logic              src_sign;
    logic [TAG_W-1:0]  src_tag;
    logic [WIDTH-1:0]  lvl_data;

    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [LEVELS-1:0] shamt_q;
    logic [1:0]        op_q;
    logic              sign_q;
    logic [TAG_W-1:0]  tag_q;

    if (s == 0) begin : g_head
      // Loads only happen on advance, where in_ready is 1, so in_valid equals the accept.
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_op    = in_op;
      assign src_sign  = in_data[WIDTH-1];
      assign src_tag   = in_tag;
    end else begin : g_body
      assign src_valid = g_stage[s-1].valid_q;
      assign src_data  = g_stage[s-1].data_q;
      assign src_shamt = g_stage[s-1].shamt_q;
      assign src_op    = g_stage[s-1].op_q;
      assign src_sign  = g_stage[s-1].sign_q;
      assign src_tag   = g_stage[s-1].tag_q;
    end

    always_comb begin
      lvl_data = src_data;
      for (int unsigned l = 0; l < LEVELS; l++) begin
        if ((l / REG_EVERY) == s && src_shamt[l]) begin
          lvl_data = shift_level(lvl_data, src_op, src_sign, 32'd1 << l);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        op_q    <= '0;
        sign_q  <= 1'b0;
        tag_q   <= '0;
      end else if (advance) begin
        valid_q <= src_valid;
        data_q  <= lvl_data;
        shamt_q <= src_shamt;
        op_q    <= src_op;
        sign_q  <= src_sign;
        tag_q   <= src_tag;
      end
    end
  end

  assign out_valid = g_stage[LAT-1].valid_q;
  assign out_data  = g_stage[LAT-1].data_q;
  assign out_tag   = g_stage[LAT-1].tag_q;
  assign out_zero  = ~|out_data;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

endmodule

// File: tb/tb_mips_pipe_shifter.sv
// Randomised and directed bench for mips_pipe_shifter against a queue-based arithmetic model.
module tb_mips_pipe_shifter;

  localparam int unsigned Lat   = 5;
  localparam int unsigned Lat64 = (6 + 6 - 1) / 6;
  localparam int unsigned Lat16 = (4 + 2 - 1) / 2;
  localparam int unsigned Lat8  = (3 + 3 - 1) / 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_zero;

  logic        sw_valid = 1'b0;
  logic [4:0]  sw_tag = '0;
  logic [63:0] d64 = '0;
  logic [15:0] d16 = '0;
  logic [7:0]  d8 = '0;
  logic        r64, r16, r8, v64, v16, v8, z64, z16, z8;
  logic [63:0] o64;
  logic [15:0] o16;
  logic [7:0]  o8;
  logic [4:0]  t64, t16, t8;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;
  int unsigned cyc = 0;
  logic        rdy_mode = 1'b0;
  logic        rdy_force = 1'b1;
  logic        chk_lat = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  logic        stall_q = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_tag;

  mips_pipe_shifter #(.WIDTH(32), .REG_EVERY(1), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_zero(out_zero)
  );

  mips_pipe_shifter #(.WIDTH(64), .REG_EVERY(6), .TAG_W(5)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r64), .in_data(d64),
    .in_shamt(6'd63), .in_op(2'b10), .in_tag(sw_tag), .out_valid(v64),
    .out_ready(1'b1), .out_data(o64), .out_tag(t64), .out_zero(z64)
  );

  mips_pipe_shifter #(.WIDTH(16), .REG_EVERY(2), .TAG_W(5)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r16), .in_data(d16),
    .in_shamt(4'd15), .in_op(2'b10), .in_tag(sw_tag), .out_valid(v16),
    .out_ready(1'b1), .out_data(o16), .out_tag(t16), .out_zero(z16)
  );

  mips_pipe_shifter #(.WIDTH(8), .REG_EVERY(3), .TAG_W(5)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8), .in_data(d8),
    .in_shamt(3'd7), .in_op(2'b10), .in_tag(sw_tag), .out_valid(v8),
    .out_ready(1'b1), .out_data(o8), .out_tag(t8), .out_zero(z8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input int unsigned sh,
                                        input logic [1:0] op);
    logic [63:0] dd;
    case (op)
      2'd0:    return d << sh;
      2'd1:    return d >> sh;
      2'd2:    return 32'($signed(d) >>> sh);
      default: begin
        dd = {d, d} >> sh;
        return dd[31:0];
      end
    endcase
  endfunction

  // Scoreboard: retire on output transfer, enqueue on accept, watch hold-stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_data", 64'(out_data), 64'(held_data));
        check("hold_tag", 64'(out_tag), 64'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("data", 64'(out_data), 64'(e.data));
          check("tag", 64'(out_tag), 64'(e.tag));
          check("zero", 64'(out_zero), 64'(e.data == 32'd0));
          if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(Lat));
        end
      end
      stall_q   = out_valid && !out_ready;
      held_data = out_data;
      held_tag  = out_tag;
      if (in_valid && in_ready) begin
        e.data = model(in_data, int'(in_shamt), in_op);
        e.tag  = in_tag;
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                      input logic [4:0] tag);
    int unsigned waited;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_tag   = tag;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned waited;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    check("rst_zero", 64'(out_zero), 64'(1));
    check("rst_ready", 64'(in_ready), 64'(1));

    // Directed ops back to back with out_ready high.
    @(posedge clk);
    #1 chk_lat = 1'b1;
    send(32'h0000_0001, 5'd31, 2'd0, 5'd1);
    send(32'h8000_0000, 5'd31, 2'd1, 5'd2);
    send(32'h8000_0000, 5'd4,  2'd2, 5'd3);
    send(32'h1234_5678, 5'd8,  2'd3, 5'd4);
    send(32'h0000_FFFF, 5'd16, 2'd0, 5'd5);
    send(32'h0000_FFFF, 5'd16, 2'd1, 5'd6);
    for (int op = 0; op < 4; op++) send(32'hDEAD_BEEF, 5'd0, 2'(op), 5'(8 + op));
    repeat (Lat + 2) @(posedge clk);

    // Random stream with random backpressure.
    #1 chk_lat = 1'b0;
    rdy_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'($urandom));
    end
    rdy_mode  = 1'b0;
    rdy_force = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      waited++;
      @(posedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'(0));

    // Fill the pipe against a stalled consumer, then release it.
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send($urandom, 5'($urandom_range(0, 31)), 2'(i % 4), 5'(20 + i));
    check("fill_valid", 64'(out_valid), 64'(1));
    check("fill_in_ready", 64'(in_ready), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_valid", 64'(out_valid), 64'(1));
    end
    rdy_force = 1'b1;
    @(posedge clk);
    #2 check("release_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_valid", 64'(out_valid), 64'(1));
    end
    @(negedge clk);
    check("drain_done", 64'(out_valid), 64'(0));

    // Reset with ops in flight.
    @(posedge clk);
    #1 chk_lat = 1'b1;
    send(32'h0F0F_0F0F, 5'd3, 2'd0, 5'd11);
    send(32'hF0F0_F0F0, 5'd5, 2'd2, 5'd12);
    send(32'h1111_2222, 5'd9, 2'd3, 5'd13);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_data", 64'(out_data), 64'(0));
    check("flush_ready", 64'(in_ready), 64'(1));
    repeat (10) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    send(32'hCAFE_0001, 5'd1, 2'd0, 5'd30);
    repeat (Lat + 2) @(posedge clk);
    check("post_rst_empty", 64'(sb.size()), 64'(0));

    // Parameter sweep: SRA of the sign bit by WIDTH-1 gives all ones after LAT cycles.
    #1;
    sw_valid = 1'b1;
    sw_tag   = 5'd17;
    d64      = 64'h8000_0000_0000_0000;
    d16      = 16'h8000;
    d8       = 8'h80;
    @(posedge clk);
    #1 sw_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("w64_valid", 64'(v64), 64'(k == int'(Lat64)));
      check("w16_valid", 64'(v16), 64'(k == int'(Lat16)));
      check("w8_valid", 64'(v8), 64'(k == int'(Lat8)));
      if (k == int'(Lat64)) check("w64_data", o64, {64{1'b1}});
      if (k == int'(Lat16)) check("w16_data", 64'(o16), 64'(16'hFFFF));
      if (k == int'(Lat8)) check("w8_data", 64'(o8), 64'(8'hFF));
      if (k == int'(Lat16)) check("w16_tag", 64'(t16), 64'(5'd17));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_pipe_shifter.md
Name: mips_pipe_shifter

Overview:
- Parametrised, pipelined barrel shifter for the MIPS datapath, generalising the 32-bit combinational shifter to any power-of-two width.
- Supports SLL/SRL/SRA/ROR with configurable register insertion between mux levels.
- Uses a valid/ready handshake with full backpressure and a sideband tag.
- Sits between the ALU issue stage and writeback, used where shifter depth limits Fmax.

Parameters:
- WIDTH, 32, data width; power of two, >= 4.
- REG_EVERY, 1, insert a pipeline register after every REG_EVERY mux levels; legal 1..LEVELS.
- TAG_W, 5, width of the sideband tag (e.g. destination register index) carried alongside data.
- Derived, not overridable: LEVELS = clog2(WIDTH); LAT = ceil(LEVELS/REG_EVERY).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  WIDTH  value to shift.
- in_shamt  in  LEVELS  shift amount, 0..WIDTH-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of this result.
- out_zero  out  1  out_data == 0.

Behaviour:
- Mux level i (i = 0..LEVELS-1) shifts by 2^i when shamt[i] = 1, else passes through.
- Per level: SLL fills zeros at LSBs; SRL fills zeros at MSBs; SRA fills copies of the original in_data[WIDTH-1]; ROR rotates right.
- Sign bit is captured at input and carried down the pipe; it is never re-read from intermediate data.
- Each pipeline register holds: valid, data, remaining shamt bits, op, sign, tag.
- Registers are placed after level indices i where (i+1) % REG_EVERY == 0, and always after the last level. Latency is therefore LAT cycles from accept to out_valid with no stall.
- LAT = 1 (REG_EVERY = LEVELS): fully combinational shift, registered output.
- Handshake:
  - Accept when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational from out_ready and the last-stage valid).
  - On advance, every stage loads from its predecessor; stage 0 loads in_valid & in_ready.
  - If ~advance, all stages hold: out_data, out_tag and out_zero stay stable while out_valid & ~out_ready.
  - Bubbles are not collapsed; one accept per cycle max; throughput 1 result/cycle when out_ready is held high.
- in_data/in_shamt/in_op/in_tag are don't-care when in_valid = 0. Stage data registers may load garbage, but valid bits are 0.
- shamt = 0: out_data = in_data for all ops.
- out_zero is registered alongside out_data, or derived combinationally from the last register; either way it is consistent with out_data in the same cycle.
- Reset:
  - All stage valid bits clear to 0, so out_valid = 0.
  - out_data = 0, out_tag = 0, out_zero = 1.
  - in_ready = 1 in the first cycle after reset deassertion.
  - Reset mid-operation discards all in-flight results; no result emerges afterward.
  - in_valid during rst is ignored.
- Simultaneous accept and output transfer in the same cycle is legal and loses nothing.
- Ordering: results emerge strictly in acceptance order.

Test Plan:
- WIDTH=32, REG_EVERY=1 (LAT=5), out_ready=1. Inject SLL 0x00000001<<31, SRL 0x80000000>>31, SRA 0x80000000>>4, ROR 0x12345678 by 8 on consecutive cycles -> 0x80000000, 0x00000001, 0xF8000000, 0x78123456 on cycles 5..8 after the first accept; tags match; out_zero=0.
- Back-to-back stream of 20 random ops; out_ready toggles pseudo-randomly -> results match the reference model in order; out_data/out_tag stable while out_valid & ~out_ready; no loss or duplication.
- Fill the pipe (5 accepts) with out_ready=0 -> in_ready drops to 0 once out_valid=1; hold 3 cycles, then out_ready=1 -> 5 results drain on consecutive cycles; in_ready=1 in the same cycle out_ready rises.
- SLL 0x0000FFFF by 16, then SRL 0x0000FFFF by 16 -> 0xFFFF0000 with out_zero=0, then 0x00000000 with out_zero=1. Any op with shamt=0 returns in_data unchanged.
- Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 and out_data=0 the next cycle; no stale result appears within 10 cycles; a fresh op issued afterward completes with latency 5.
- Parameter sweep: WIDTH=64 REG_EVERY=6 (LAT=1); WIDTH=16 REG_EVERY=2 (LAT=2); WIDTH=8 REG_EVERY=3 (LAT=1). SRA 0x80..0 by WIDTH-1 -> all ones; latency matches ceil(LEVELS/REG_EVERY).
